// File: rtl/pkt_trailer_append.sv
// pkt_trailer_append
// Forwards a valid/ready/last byte stream unchanged and appends a 3-byte
// trailer to every packet: length high byte, length low byte, and the
// modulo-256 sum of the payload bytes. The output is a single registered
// AXI-stream stage. pkt_done / pkt_oversize pulse on the cycle the checksum
// byte first appears on m_tdata.
module pkt_trailer_append #(
  parameter int MAX_LEN = 1500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  input  logic       m_tready,
  output logic       pkt_done,
  output logic       pkt_oversize
);

  typedef enum logic [1:0] {
    PAY    = 2'd0,
    LEN_HI = 2'd1,
    LEN_LO = 2'd2,
    CHK    = 2'd3
  } state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      state;
  state_t      next_state;
  logic [15:0] len;
  logic [15:0] next_len;
  logic [7:0]  sum;
  logic [7:0]  next_sum;

  // Output-register load request produced by the state machine.
  logic        slot;
  logic        load;
  logic [7:0]  load_data;
  logic        load_last;
  logic        done_next;
  logic        oversize_next;

  // The output register can take a new byte when it is empty or draining.
  assign slot     = !m_tvalid || m_tready;
  assign in_ready = (state == PAY) && slot;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PAY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the byte to load into the output register.
  // NOTE: every signal gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    next_state    = state;
    next_len      = len;
    next_sum      = sum;
    load          = 1'b0;
    load_data     = 8'd0;
    load_last     = 1'b0;
    done_next     = 1'b0;
    oversize_next = 1'b0;
    unique case (state)
      PAY: begin
        if (in_valid && in_ready) begin
          load      = 1'b1;
          load_data = in_data;
          next_len  = len + 16'd1;
          next_sum  = sum + in_data;
          if (in_last) begin
            next_state = LEN_HI;
          end
        end
      end
      LEN_HI: begin
        if (slot) begin
          load       = 1'b1;
          load_data  = len[15:8];
          next_state = LEN_LO;
        end
      end
      LEN_LO: begin
        if (slot) begin
          load       = 1'b1;
          load_data  = len[7:0];
          next_state = CHK;
        end
      end
      CHK: begin
        if (slot) begin
          load          = 1'b1;
          load_data     = sum;
          load_last     = 1'b1;
          done_next     = 1'b1;
          oversize_next = (len > MAX_LEN_W);
          next_len      = 16'd0;
          next_sum      = 8'd0;
          next_state    = PAY;
        end
      end
      default: next_state = PAY;
    endcase
  end

  // Running length and checksum of the current packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len <= 16'd0;
      sum <= 8'd0;
    end else begin
      len <= next_len;
      sum <= next_sum;
    end
  end

  // Output register: loads on slot, holds everything while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= 8'd0;
      m_tlast  <= 1'b0;
    end else if (slot) begin
      m_tvalid <= load;
      if (load) begin
        m_tdata <= load_data;
        m_tlast <= load_last;
      end
    end
  end

  // Packet-completion pulses, aligned with the checksum byte's first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_done     <= 1'b0;
      pkt_oversize <= 1'b0;
    end else begin
      pkt_done     <= done_next;
      pkt_oversize <= oversize_next;
    end
  end

endmodule
